// File: rtl/div_nbits_seq_if.sv
// Start/done handshake and operand/result bus for the iterative divider.
// The master drives the operands; the slave returns the registered results.
interface div_nbits_seq_if #(
    parameter int width = 8
);
    logic             start_i;
    logic [width-1:0] a_i;
    logic [width-1:0] b_i;
    logic [width-1:0] q_o;
    logic [width-1:0] r_o;
    logic             busy_o;
    logic             done_o;
    logic             div0_o;

    modport master (
        output start_i, a_i, b_i,
        input  q_o, r_o, busy_o, done_o, div0_o
    );

    modport slave (
        input  start_i, a_i, b_i,
        output q_o, r_o, busy_o, done_o, div0_o
    );
endinterface

// File: rtl/div_nbits_seq.sv
// Iterative unsigned restoring divider: one trial subtraction per cycle.
// A start/done handshake exposes the width-cycle latency; division by zero finishes at once.
module div_nbits_seq #(
    parameter int width = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    div_nbits_seq_if.slave bus
);
    localparam int CNT_W = $clog2(width + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(width - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_r, state_s;
    logic [width:0]   rem_r, rem_s;
    logic [width-1:0] quo_r, quo_s;
    logic [width-1:0] b_r, b_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [width-1:0] q_r, q_s;
    logic [width-1:0] r_r, r_s;
    logic             div0_r, div0_s;
    logic             busy_r, done_r;
    logic [width+1:0] shifted_s;
    logic [width+1:0] trial_s;
    logic             borrow_s;

    // Trial subtraction on the shifted partial remainder; the extra top bit catches the borrow.
    always_comb begin
        shifted_s = {rem_r, quo_r[width-1]};
        trial_s   = shifted_s - {2'b00, b_r};
        borrow_s  = trial_s[width+1];
    end

    // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_s = state_r;
        rem_s   = rem_r;
        quo_s   = quo_r;
        b_s     = b_r;
        cnt_s   = cnt_r;
        q_s     = q_r;
        r_s     = r_r;
        div0_s  = div0_r;
        case (state_r)
            IDLE: begin
                if (bus.start_i) begin
                    if (bus.b_i != {width{1'b0}}) begin
                        // The dividend enters through quo and shifts out as quotient bits shift in.
                        b_s     = bus.b_i;
                        rem_s   = {(width + 1){1'b0}};
                        quo_s   = bus.a_i;
                        cnt_s   = {CNT_W{1'b0}};
                        state_s = RUN;
                    end else begin
                        q_s     = {width{1'b1}};
                        r_s     = bus.a_i;
                        div0_s  = 1'b1;
                        state_s = DONE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (borrow_s) begin
                    rem_s = shifted_s[width:0];
                end else begin
                    rem_s = trial_s[width:0];
                end
                quo_s = {quo_r[width-2:0], ~borrow_s};
                cnt_s = cnt_r + CNT_W'(1);
                if (cnt_r == LAST) begin
                    q_s     = quo_s;
                    r_s     = rem_s[width-1:0];
                    div0_s  = 1'b0;
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and output registers; reset aborts any division in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            rem_r   <= {(width + 1){1'b0}};
            quo_r   <= {width{1'b0}};
            b_r     <= {width{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            q_r     <= {width{1'b0}};
            r_r     <= {width{1'b0}};
            div0_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            rem_r   <= rem_s;
            quo_r   <= quo_s;
            b_r     <= b_s;
            cnt_r   <= cnt_s;
            q_r     <= q_s;
            r_r     <= r_s;
            div0_r  <= div0_s;
            busy_r  <= (state_s == RUN);
            done_r  <= (state_s == DONE);
        end
    end

    assign bus.q_o    = q_r;
    assign bus.r_o    = r_r;
    assign bus.div0_o = div0_r;
    assign bus.busy_o = busy_r;
    assign bus.done_o = done_r;
endmodule

// File: tb/tb_div_nbits_seq.sv
// Scoreboard bench for div_nbits_seq at width 8 and width 16.
// Expected results are queued when a start is driven and popped on each done pulse.
module tb_div_nbits_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    div_nbits_seq_if #(.width(8))  bus8  ();
    div_nbits_seq_if #(.width(16)) bus16 ();

    div_nbits_seq #(.width(8)) dut8 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus8.slave)
    );

    div_nbits_seq #(.width(16)) dut16 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus16.slave)
    );

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic [31:0] d0;
    } exp_t;

    exp_t sb8[$];
    exp_t sb16[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard pop for the 8-bit divider on every done pulse.
    always @(negedge clk) begin
        if (bus8.done_o === 1'b1) begin
            if (sb8.size() == 0) begin
                check("done8_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb8.pop_front();
                check("q8", {24'd0, bus8.q_o}, e.q);
                check("r8", {24'd0, bus8.r_o}, e.r);
                check("div0_8", {31'd0, bus8.div0_o}, e.d0);
            end
        end
    end

    // Scoreboard pop for the 16-bit divider on every done pulse.
    always @(negedge clk) begin
        if (bus16.done_o === 1'b1) begin
            if (sb16.size() == 0) begin
                check("done16_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb16.pop_front();
                check("q16", {16'd0, bus16.q_o}, e.q);
                check("r16", {16'd0, bus16.r_o}, e.r);
                check("div0_16", {31'd0, bus16.div0_o}, e.d0);
            end
        end
    end

    function automatic logic sel_done(input int w);
        return (w == 8) ? bus8.done_o : bus16.done_o;
    endfunction

    function automatic logic sel_busy(input int w);
        return (w == 8) ? bus8.busy_o : bus16.busy_o;
    endfunction

    task automatic drive(input int w, input logic start, input logic [31:0] a, input logic [31:0] b);
        if (w == 8) begin
            bus8.start_i = start;
            bus8.a_i     = a[7:0];
            bus8.b_i     = b[7:0];
        end else begin
            bus16.start_i = start;
            bus16.a_i     = a[15:0];
            bus16.b_i     = b[15:0];
        end
    endtask

    // One operation: queue the expected result, measure latency and busy cycles.
    // poke_at > 0 pulses a conflicting start at that cycle of the run.
    task automatic do_op(input int w, input logic [31:0] a, input logic [31:0] b, input int poke_at);
        exp_t        e;
        int          lat;
        int          busy_cnt;
        logic [31:0] ones;
        ones = (w == 8) ? 32'h0000_00FF : 32'h0000_FFFF;
        if (b == 32'd0) begin
            e.q  = ones;
            e.r  = a;
            e.d0 = 32'd1;
        end else begin
            e.q  = a / b;
            e.r  = a % b;
            e.d0 = 32'd0;
        end
        if (w == 8) sb8.push_back(e);
        else        sb16.push_back(e);
        drive(w, 1'b1, a, b);
        lat      = 0;
        busy_cnt = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == poke_at) drive(w, 1'b1, 32'd200, 32'd3);
            else                drive(w, 1'b0, 32'd0, 32'd0);
            if (sel_busy(w) === 1'b1) busy_cnt++;
        end while (sel_done(w) !== 1'b1 && lat < 100);
        check("latency", lat, (b == 32'd0) ? 32'd1 : 32'(w + 1));
        check("busy_cycles", busy_cnt, (b == 32'd0) ? 32'd0 : 32'(w));
        @(negedge clk);
        check("done_one_cycle", {31'd0, sel_done(w)}, 32'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int          seen;
        drive(8, 1'b0, 32'd0, 32'd0);
        drive(16, 1'b0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_q8", {24'd0, bus8.q_o}, 32'd0);
        check("rst_r8", {24'd0, bus8.r_o}, 32'd0);
        check("rst_busy8", {31'd0, bus8.busy_o}, 32'd0);
        check("rst_done8", {31'd0, bus8.done_o}, 32'd0);
        check("rst_div0_8", {31'd0, bus8.div0_o}, 32'd0);
        check("rst_q16", {16'd0, bus16.q_o}, 32'd0);

        do_op(8, 32'd100, 32'd7, 0);
        do_op(8, 32'd255, 32'd1, 0);
        do_op(8, 32'd5, 32'd9, 0);
        do_op(8, 32'd0, 32'd3, 0);
        do_op(8, 32'd37, 32'd0, 0);
        check("hold_q8", {24'd0, bus8.q_o}, 32'h0000_00FF);
        check("hold_div0_8", {31'd0, bus8.div0_o}, 32'd1);
        do_op(8, 32'd9, 32'd3, 0);
        do_op(8, 32'd100, 32'd7, 4);

        // Reset lands on E3 of a 100/7 run: no done, outputs cleared.
        drive(8, 1'b1, 32'd100, 32'd7);
        @(negedge clk);
        drive(8, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_q8", {24'd0, bus8.q_o}, 32'd0);
        check("abort_r8", {24'd0, bus8.r_o}, 32'd0);
        check("abort_busy8", {31'd0, bus8.busy_o}, 32'd0);
        check("abort_done8", {31'd0, bus8.done_o}, 32'd0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus8.done_o === 1'b1) seen++;
        end
        check("abort_no_done", seen, 32'd0);
        do_op(8, 32'd9, 32'd3, 0);

        do_op(16, 32'd65535, 32'd1, 0);
        do_op(16, 32'd1234, 32'd0, 0);
        for (int i = 0; i < 10; i++) begin
            ra = $urandom_range(255, 0);
            rb = $urandom_range(255, 1);
            do_op(8, ra, rb, 0);
            $display("vec8 %0d a=%0d b=%0d done", i, ra, rb);
        end
        for (int i = 0; i < 10; i++) begin
            ra = $urandom_range(65535, 0);
            rb = $urandom_range(65535, 1);
            do_op(16, ra, rb, 0);
            $display("vec16 %0d a=%0d b=%0d done", i, ra, rb);
        end

        check("sb8_empty", sb8.size(), 32'd0);
        check("sb16_empty", sb16.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
